// File: rtl/neuron_spike_aer_out.sv
// AER output stage: buffers {tick, neuron index} spike events in a FIFO and
// drains them over a 4-phase REQ/ACK link.
`timescale 1ns/1ps
module neuron_spike_aer_out #(
  parameter int N     = 256,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(N),
  localparam int PW   = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          neuron_spike_i,
  input  logic [AW-1:0] neuron_addr_i,
  input  logic [7:0]    tick_i,
  input  logic          aer_en_i,
  input  logic          flush_i,
  output logic [AW+7:0] AEROUT_ADDR,
  output logic          AEROUT_REQ,
  input  logic          AEROUT_ACK,
  output logic [PW-1:0] fifo_level_o,
  output logic          fifo_full_o,
  output logic [15:0]   drop_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAITLOW} state_t;

  state_t          state;
  state_t          next_state;
  logic            ack_meta;
  logic            ack_s;
  logic [AW+7:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            drop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = neuron_spike_i && !full && !flush_i;
  assign drop  = neuron_spike_i && full && !flush_i;

  assign fifo_level_o = wr_ptr - rd_ptr;
  assign fifo_full_o  = full;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= AEROUT_ACK;
      ack_s    <= ack_meta;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[PW-2:0]] <= {tick_i, neuron_addr_i};
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)
      drop_cnt_o <= '0;
    else if (drop && drop_cnt_o != 16'hFFFF)
      drop_cnt_o <= drop_cnt_o + 16'd1;
  end

  // The pop decision uses the pre-edge empty flag, so a same-cycle push is
  // never read back before it has been written.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (aer_en_i && !empty && !ack_s) begin
          pop        = 1'b1;
          next_state = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_s) next_state = S_WAITLOW;
      end
      S_WAITLOW: begin
        if (!ack_s) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= S_IDLE;
      AEROUT_REQ  <= 1'b0;
      AEROUT_ADDR <= '0;
    end else begin
      state      <= next_state;
      AEROUT_REQ <= (next_state == S_REQ);
      if (pop) AEROUT_ADDR <= mem[rd_ptr[PW-2:0]];
    end
  end

endmodule

// File: tb/tb_neuron_spike_aer_out.sv
// Bench for neuron_spike_aer_out: directed and random spikes checked every
// cycle against a queue-based model of the event buffer and AER handshake.
`timescale 1ns/1ps
module tb_neuron_spike_aer_out;

  localparam int N     = 256;
  localparam int DEPTH = 16;
  localparam int PW    = 5;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        spike = 1'b0;
  logic [7:0]  addr = '0;
  logic [7:0]  tick = '0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] aer_addr;
  logic        aer_req;
  logic [PW-1:0] level;
  logic        full;
  logic [15:0] drops;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  // Reference model: event queue, drop count, handshake phase and the
  // two-edge delayed view of ACK that the link logic acts on.
  logic [15:0] q[$];
  int          m_drops;
  int          phase;
  bit          ack_meta_m;
  bit          ack_s_m;
  bit          m_req;
  logic [15:0] m_addr;

  logic [15:0] w1, w2, w3;

  neuron_spike_aer_out #(.N(N), .DEPTH(DEPTH)) dut (
    .CLK(clk),
    .RSTN(rstn),
    .neuron_spike_i(spike),
    .neuron_addr_i(addr),
    .tick_i(tick),
    .aer_en_i(en),
    .flush_i(flush),
    .AEROUT_ADDR(aer_addr),
    .AEROUT_REQ(aer_req),
    .AEROUT_ACK(ack),
    .fifo_level_o(level),
    .fifo_full_o(full),
    .drop_cnt_o(drops)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_drops    = 0;
    phase      = 0;
    ack_meta_m = 1'b0;
    ack_s_m    = 1'b0;
    m_req      = 1'b0;
    m_addr     = '0;
  endtask

  // One clock edge of the model, using the inputs held across the edge.
  task automatic model_update();
    bit full_b;
    bit empty_b;
    bit ack_seen;
    if (!rstn) begin
      model_reset();
    end else begin
      full_b     = (q.size() == DEPTH);
      empty_b    = (q.size() == 0);
      ack_seen   = ack_s_m;
      ack_s_m    = ack_meta_m;
      ack_meta_m = ack;
      if (phase == 0) begin
        if (en && !empty_b && !ack_seen) begin
          m_addr = q.pop_front();
          m_req  = 1'b1;
          phase  = 1;
        end
      end else if (phase == 1) begin
        if (ack_seen) begin
          m_req = 1'b0;
          phase = 2;
        end
      end else begin
        if (!ack_seen) phase = 0;
      end
      if (flush) q.delete();
      else if (spike) begin
        if (!full_b) q.push_back({tick, addr});
        else if (m_drops < 65535) m_drops++;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic check_model();
    checkOutput("req",   32'(aer_req), 32'(m_req));
    checkOutput("addr",  32'(aer_addr), 32'(m_addr));
    checkOutput("level", 32'(level), 32'(q.size()));
    checkOutput("full",  32'(full), 32'(q.size() == DEPTH));
    checkOutput("drops", 32'(drops), 32'(m_drops));
  endtask

  // Drive one cycle of inputs, clock once, then compare against the model.
  task automatic applyStimulus(input bit s, input logic [7:0] a, input logic [7:0] t,
                               input bit f);
    spike = s;
    addr  = a;
    tick  = t;
    flush = f;
    @(posedge clk);
    model_update();
    #1;
    check_model();
    spike = 1'b0;
    flush = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 8'($urandom), 8'($urandom), 1'b0);
  endtask

  task automatic wait_req(input bit val, input int budget, input string tag);
    int n;
    n = 0;
    while (aer_req !== val && n < budget) begin
      applyStimulus(1'b0, 8'($urandom), 8'($urandom), 1'b0);
      n++;
    end
    checkOutput(tag, 32'(aer_req), 32'(val));
  endtask

  initial begin
    model_reset();
    #3 rstn = 1'b0;
    #1;
    checkOutput("rst_req",   32'(aer_req), 32'd0);
    checkOutput("rst_addr",  32'(aer_addr), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_full",  32'(full), 32'd0);
    checkOutput("rst_drops", 32'(drops), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Single event: REQ two edges after the spike, falls three edges after ACK.
    en = 1'b1;
    applyStimulus(1'b1, 8'h2A, 8'h05, 1'b0);
    checkOutput("single_req_early", 32'(aer_req), 32'd0);
    checkOutput("single_level", 32'(level), 32'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("single_req", 32'(aer_req), 32'd1);
    checkOutput("single_addr", 32'(aer_addr), 32'h052A);
    ack = 1'b1;
    idle_cycles(2);
    checkOutput("single_req_hold", 32'(aer_req), 32'd1);
    idle_cycles(1);
    checkOutput("single_req_fall", 32'(aer_req), 32'd0);
    ack = 1'b0;
    idle_cycles(4);
    checkOutput("single_level_end", 32'(level), 32'd0);

    // Fill with the link disabled; the last four spikes are dropped.
    en = 1'b0;
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 8'(i), 8'($urandom), 1'b0);
    checkOutput("fill_level", 32'(level), 32'd16);
    checkOutput("fill_full",  32'(full), 32'd1);
    checkOutput("fill_drops", 32'(drops), 32'd4);

    // Pop and spike in the same cycle while full: the spike is still dropped.
    en = 1'b1;
    applyStimulus(1'b1, 8'hEE, 8'h77, 1'b0);
    checkOutput("pushpop_drops", 32'(drops), 32'd5);
    checkOutput("pushpop_level", 32'(level), 32'd15);
    checkOutput("pushpop_req",   32'(aer_req), 32'd1);

    for (int i = 0; i < 16; i++) begin
      wait_req(1'b1, 12, "drain_req_rise");
      checkOutput("drain_order", 32'(aer_addr[7:0]), 32'(i));
      ack = 1'b1;
      wait_req(1'b0, 12, "drain_req_fall");
      ack = 1'b0;
    end
    idle_cycles(4);
    checkOutput("drain_level", 32'(level), 32'd0);

    // Slow ACK: REQ and ADDR hold for 50 cycles; a short ACK glitch after
    // REQ falls must not let the next queued event through.
    w1 = 16'($urandom);
    w2 = 16'($urandom);
    applyStimulus(1'b1, w1[7:0], w1[15:8], 1'b0);
    applyStimulus(1'b1, w2[7:0], w2[15:8], 1'b0);
    checkOutput("slow_req", 32'(aer_req), 32'd1);
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, 8'($urandom), 8'($urandom), 1'b0);
      checkOutput("slow_req_hold",  32'(aer_req), 32'd1);
      checkOutput("slow_addr_hold", 32'(aer_addr), 32'(w1));
    end
    ack = 1'b1;
    wait_req(1'b0, 12, "slow_req_fall");
    #2 ack = 1'b0;
    #3 ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'($urandom), 8'($urandom), 1'b0);
      checkOutput("glitch_no_req", 32'(aer_req), 32'd0);
    end
    ack = 1'b0;
    wait_req(1'b1, 12, "second_req");
    checkOutput("second_addr", 32'(aer_addr), 32'(w2));
    ack = 1'b1;
    wait_req(1'b0, 12, "second_req_fall");
    ack = 1'b0;
    idle_cycles(4);

    // Flush with a same-cycle spike: queue empties, drop count untouched.
    en = 1'b0;
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    checkOutput("flush_pre_level", 32'(level), 32'd5);
    applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'b1);
    checkOutput("flush_level", 32'(level), 32'd0);
    checkOutput("flush_drops", 32'(drops), 32'd5);
    w3 = 16'($urandom);
    applyStimulus(1'b1, w3[7:0], w3[15:8], 1'b0);
    en = 1'b1;
    wait_req(1'b1, 12, "flush_next_req");
    checkOutput("flush_next_addr", 32'(aer_addr), 32'(w3));
    ack = 1'b1;
    wait_req(1'b0, 12, "flush_next_fall");
    ack = 1'b0;
    idle_cycles(4);

    // Random traffic with a randomly delayed ACK responder.
    for (int c = 0; c < 400; c++) begin
      if (c % 16 == 0) en = ($urandom_range(0, 3) != 0);
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 63) == 0));
      if (aer_req && !ack && $urandom_range(0, 2) == 0) ack = 1'b1;
      else if (!aer_req && ack && $urandom_range(0, 2) == 0) ack = 1'b0;
    end

    // Quiesce: empty the queue and let any open handshake finish.
    en = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 8'($urandom), 8'($urandom), 1'b0);
      ack = aer_req;
    end
    ack = 1'b0;
    idle_cycles(6);

    // Reset mid-handshake with three events still queued.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    checkOutput("midrst_req_pre",   32'(aer_req), 32'd1);
    checkOutput("midrst_level_pre", 32'(level), 32'd3);
    #2 rstn = 1'b0;
    #1;
    checkOutput("midrst_req",   32'(aer_req), 32'd0);
    checkOutput("midrst_level", 32'(level), 32'd0);
    checkOutput("midrst_drops", 32'(drops), 32'd0);
    checkOutput("midrst_addr",  32'(aer_addr), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'($urandom), 8'($urandom), 1'b0);
      checkOutput("postrst_no_req", 32'(aer_req), 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
